ifetch_prefetch_queue: RTL and testbench
========================================

// Module: ifetch_prefetch_queue
// PURPOSE
//  Instruction prefetch queue between the core fetch stage and instruction memory.
//  Issues sequential 32-bit fetches on a req/gnt/rvalid port and buffers up to DEPTH returned
//  words tagged with their PC. Delivers them to fetch over valid/ready.
//  On a PC redirect it flushes buffered words and discards in-flight responses.
// PARAMETERS
//  DEPTH            4       queue entries; power of two, >=2
//  MAX_OUTSTANDING  2       max granted-but-unreturned requests; 1..DEPTH
//  RESET_PC         64'h0   first fetch address after reset
// PORTS
//  clk            in   1   clock; all state on rising edge
//  rst            in   1   synchronous reset, active-high
//  redirect_i     in   1   branch/jump redirect from EX
//  redirect_pc_i  in   64  new fetch PC; bits [1:0] ignored (treated as 0)
//  instr_valid_o  out  1   head entry valid
//  instr_ready_i  in   1   fetch accepts head entry
//  instr_o        out  32  head instruction word
//  instr_pc_o     out  64  PC of head word
//  instr_err_o    out  1   head word returned with bus error
//  mem_req_o      out  1   fetch request
//  mem_addr_o     out  64  request address, word aligned
//  mem_gnt_i      in   1   request accepted this cycle
//  mem_rvalid_i   in   1   response valid; responses return in request order
//  mem_rdata_i    in   32  response data
//  mem_err_i      in   1   response error, qualified by mem_rvalid_i
// BEHAVIOUR
//  Reset:
//   - fetch_pc=RESET_PC; occupancy, outstanding and discard_cnt = 0; state=RUN.
//   - mem_req_o=0 and instr_valid_o=0 during reset and in the first cycle after it.
//  FSM states:
//   - RUN: issue enabled.
//   - FLUSH: issue blocked until discard_cnt==0, then RUN.
//   - Redirect in RUN or FLUSH: go to FLUSH if remaining outstanding>0, else stay in RUN.
//  Issue (RUN only):
//   - mem_req_o = !redirect_i && (occupancy+outstanding < DEPTH) && (outstanding < MAX_OUTSTANDING).
//   - mem_addr_o = fetch_pc. req/addr are combinational from state.
//   - Our port allows an ungranted request to be withdrawn.
//  Grant (mem_req_o && mem_gnt_i): fetch_pc += 4 (64-bit wrap); outstanding++.
//  Response:
//   - If discard_cnt>0: drop the word, discard_cnt--, outstanding--.
//   - Otherwise push {pc, rdata, err} and outstanding--. Entry PC comes from a resp_pc
//     register that advances by 4 per accepted response.
//   - The credit rule guarantees no push when full; assert it.
//  Delivery: registered FIFO head. Pop on instr_valid_o && instr_ready_i.
//   - Push and pop in the same cycle are allowed and occupancy is unchanged.
//   - No rdata->instr bypass. A word is visible 1 cycle after its rvalid.
//  Redirect (highest priority, applied at the end of the cycle):
//   - Occupancy=0; instr_valid_o=0 next cycle.
//   - fetch_pc = resp_pc = {redirect_pc_i[63:2],2'b0}.
//   - discard_cnt = outstanding after this cycle's grant and response (a grant in this cycle counts).
//   - A pop in the redirect cycle still completes.
//  Latency: with nothing in flight, the redirect in cycle N gives mem_req_o at the new PC in N+1.
//   Zero-wait memory (gnt same cycle, rvalid next cycle) gives instr_valid_o in N+3.
//  Widths: occupancy is $clog2(DEPTH+1) bits; outstanding and discard_cnt are $clog2(MAX_OUTSTANDING+1) bits.
//  Reset mid-operation: all state cleared. Late responses are not tracked; the memory is also reset by rst.
// STRUCTURE
//  riscv_pkg additions:
//   - typedef struct packed {logic [63:0] pc; logic [31:0] instr; logic err;} ifq_entry_t.
//   - typedef enum logic {IFQ_RUN, IFQ_FLUSH} ifq_state_t.
//  One sub-module ifq_fifo: sync FIFO of ifq_entry_t with DEPTH, push, pop, flush, count.
//  Issue/credit/discard logic lives in the top.
// TESTING
//  1. Reset, gnt=1, rvalid 1 cycle after gnt, ready=1 -> addrs 0,4,8...
//     instr_pc_o tracks them with instr_o = memory word; sustained 1 instr/cycle.
//  2. ready=0 with DEPTH=4 -> exactly 4 grants then mem_req_o=0.
//     Raising ready for one cycle allows exactly one new request.
//  3. Two requests granted, then redirect to 0x1002 -> both responses dropped.
//     Next delivered instr_pc_o=0x1000; no request is issued until both responses return.
//  4. Redirect in the same cycle as a grant and an rvalid -> discard_cnt correct.
//     No stale word is delivered and the first word after the redirect comes from the new PC.
//  5. mem_err_i=1 on the response for 0x8 -> entry has instr_err_o=1; neighbouring entries have err=0.
//  6. gnt held low for 5 cycles -> mem_req_o and mem_addr_o stable.
//     Redirect during the stall -> addr changes to the new PC next cycle and no discard is counted.

Source files
------------

// File: rtl/ifetch_prefetch_queue_pkg.sv
// Shared types and helpers for the instruction prefetch queue.
package ifetch_prefetch_queue_pkg;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        err;
  } ifq_entry_t;

  typedef enum logic {
    IFQ_RUN   = 1'b0,
    IFQ_FLUSH = 1'b1
  } ifq_state_t;

  localparam logic [63:0] IFQ_PC_STEP = 64'd4;

  // Fetch addresses are always word aligned; the low two bits are dropped.
  function automatic logic [63:0] ifq_align_pc(input logic [63:0] pc);
    return pc & ~64'd3;
  endfunction

endpackage

// File: rtl/ifetch_prefetch_queue_chk.sv
// Invariant checks for the prefetch queue credit scheme.
module ifetch_prefetch_queue_chk #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2,
  localparam int OW = $clog2(MAX_OUTSTANDING + 1)
) (
  input logic          clk,
  input logic          rst,
  input logic          push,
  input logic          full,
  input logic [OW-1:0] outstanding
);

  // The credit rule reserves a slot for every outstanding request.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

  a_outstanding_bound: assert property (@(posedge clk) disable iff (rst)
                                        outstanding <= OW'(MAX_OUTSTANDING));

endmodule

// File: rtl/ifetch_prefetch_queue_fifo.sv
// Synchronous FIFO of fetched instruction entries with a flush that empties it in one cycle.
module ifq_fifo
  import ifetch_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  ifq_entry_t    push_data,
  input  logic          pop,
  input  logic          flush,
  output ifq_entry_t    head,
  output logic [CW-1:0] count,
  output logic          full
);

  ifq_entry_t    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && (count_r != CW'(0));
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping; flush discards everything buffered.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/ifetch_prefetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches, buffers tagged responses,
// and on redirect flushes the buffer and discards responses still in flight.
module ifetch_prefetch_queue
  import ifetch_prefetch_queue_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [63:0] RESET_PC        = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [63:0] instr_pc_o,
  output logic        instr_err_o,
  output logic        mem_req_o,
  output logic [63:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = CW + 1;

  ifq_state_t    state_r;
  logic [63:0]   fetch_pc_r;
  logic [63:0]   resp_pc_r;
  logic [OW-1:0] outstanding_r;
  logic [OW-1:0] discard_cnt_r;
  logic          issue_en_r;

  logic [63:0]   redirect_pc_s;
  logic          credit_ok_s;
  logic          grant_s;
  logic          drop_s;
  logic          accept_s;
  logic          pop_s;
  logic [OW-1:0] outstanding_nxt_s;
  logic [OW-1:0] discard_left_s;
  logic [CW-1:0] fifo_count_s;
  logic          fifo_full_s;
  ifq_entry_t    head_s;
  ifq_entry_t    push_entry_s;

  assign redirect_pc_s = ifq_align_pc(redirect_pc_i);
  assign credit_ok_s   = ((SW'(fifo_count_s) + SW'(outstanding_r)) < SW'(DEPTH)) &&
                         (outstanding_r < OW'(MAX_OUTSTANDING));
  // issue_en_r holds requests off for the first cycle out of reset.
  assign mem_req_o     = issue_en_r && (state_r == IFQ_RUN) && !redirect_i && credit_ok_s;
  assign mem_addr_o    = fetch_pc_r;
  assign grant_s       = mem_req_o && mem_gnt_i;
  assign drop_s        = mem_rvalid_i && (discard_cnt_r != OW'(0));
  assign accept_s      = mem_rvalid_i && !drop_s;
  assign pop_s         = instr_valid_o && instr_ready_i;
  assign push_entry_s  = '{pc: resp_pc_r, instr: mem_rdata_i, err: mem_err_i};

  // Outstanding count after this cycle's grant and response; seeds discard_cnt on redirect.
  always_comb begin
    outstanding_nxt_s = outstanding_r;
    case ({grant_s, mem_rvalid_i})
      2'b10:   outstanding_nxt_s = outstanding_r + OW'(1);
      2'b01:   outstanding_nxt_s = outstanding_r - OW'(1);
      default: outstanding_nxt_s = outstanding_r;
    endcase
    if (drop_s) begin
      discard_left_s = discard_cnt_r - OW'(1);
    end else begin
      discard_left_s = discard_cnt_r;
    end
  end

  // Fetch PC, response PC, credit counters and RUN/FLUSH state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IFQ_RUN;
      fetch_pc_r    <= RESET_PC;
      resp_pc_r     <= RESET_PC;
      outstanding_r <= OW'(0);
      discard_cnt_r <= OW'(0);
      issue_en_r    <= 1'b0;
    end else begin
      issue_en_r    <= 1'b1;
      outstanding_r <= outstanding_nxt_s;
      if (redirect_i) begin
        fetch_pc_r    <= redirect_pc_s;
        resp_pc_r     <= redirect_pc_s;
        discard_cnt_r <= outstanding_nxt_s;
        state_r       <= (outstanding_nxt_s != OW'(0)) ? IFQ_FLUSH : IFQ_RUN;
      end else begin
        if (grant_s) begin
          fetch_pc_r <= fetch_pc_r + IFQ_PC_STEP;
        end
        if (accept_s) begin
          resp_pc_r <= resp_pc_r + IFQ_PC_STEP;
        end
        discard_cnt_r <= discard_left_s;
        case (state_r)
          IFQ_RUN:   state_r <= IFQ_RUN;
          IFQ_FLUSH: state_r <= (discard_left_s == OW'(0)) ? IFQ_RUN : IFQ_FLUSH;
          default:   state_r <= IFQ_RUN;
        endcase
      end
    end
  end

  ifq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (accept_s),
    .push_data(push_entry_s),
    .pop      (pop_s),
    .flush    (redirect_i),
    .head     (head_s),
    .count    (fifo_count_s),
    .full     (fifo_full_s)
  );

  assign instr_valid_o = (fifo_count_s != CW'(0));
  assign instr_o       = head_s.instr;
  assign instr_pc_o    = head_s.pc;
  assign instr_err_o   = head_s.err;

  ifetch_prefetch_queue_chk #(
    .DEPTH          (DEPTH),
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_chk (
    .clk        (clk),
    .rst        (rst),
    .push       (accept_s),
    .full       (fifo_full_s),
    .outstanding(outstanding_r)
  );

endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// Scoreboard bench for the prefetch queue: an in-order memory model with configurable
// latency feeds expected entries that are compared as fetch pops them.
module tb_ifetch_prefetch_queue;
  import ifetch_prefetch_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_i;
  logic [63:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [63:0] instr_pc_o;
  logic        instr_err_o;
  logic        mem_req_o;
  logic [63:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;

  always #5 clk = ~clk;

  ifetch_prefetch_queue #(
    .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(64'h0)
  ) dut (
    .clk(clk), .rst(rst),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_err_o(instr_err_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
  );

  typedef struct {
    logic [63:0] addr;
    int          epoch;
    int          due;
  } pend_t;

  pend_t       pend[$];
  ifq_entry_t  exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          lat = 1;
  int          n_pops = 0;
  int          n_grants = 0;
  int          n_err_seen = 0;
  logic        redir_v, ready_v, gnt_v, watch_flush;
  logic [63:0] redir_pc_v;
  logic [63:0] err_addr;
  logic [63:0] exp_pc;
  logic        req_q, valid_q;
  logic [63:0] addr_q;

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, sample outputs mid-cycle, update the model, advance.
  task automatic step();
    pend_t r;
    logic  rv;
    logic  busy;
    ifq_entry_t e;
    r.addr = 64'h0; r.epoch = 0; r.due = 0;
    rv = 1'b0;
    redirect_i    = redir_v;
    redirect_pc_i = redir_pc_v;
    instr_ready_i = ready_v;
    mem_gnt_i     = gnt_v;
    busy = watch_flush && (pend.size() > 0);
    if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
      r  = pend.pop_front();
      rv = 1'b1;
    end
    mem_rvalid_i = rv;
    mem_rdata_i  = rv ? word_of(r.addr) : 32'h0;
    mem_err_i    = rv && (r.addr == err_addr);
    #1;
    req_q = mem_req_o; addr_q = mem_addr_o; valid_q = instr_valid_o;
    if (busy) check("req_in_flush", 64'(mem_req_o), 64'd0);
    if (!rst && instr_valid_o && instr_ready_i) begin
      n_pops++;
      if (exp_q.size() == 0) begin
        check("spurious_instr", 64'(instr_valid_o), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("instr_pc", instr_pc_o, e.pc);
        check("instr", 64'(instr_o), 64'(e.instr));
        check("instr_err", 64'(instr_err_o), 64'(e.err));
        if (instr_err_o) n_err_seen++;
      end
    end
    if (!rst && mem_req_o && mem_gnt_i) begin
      check("grant_addr", mem_addr_o, exp_pc);
      pend.push_back('{addr: mem_addr_o, epoch: epoch, due: cyc + lat});
      exp_pc += 64'd4;
      n_grants++;
    end
    if (rv && r.epoch == epoch) begin
      exp_q.push_back('{pc: r.addr, instr: word_of(r.addr), err: (r.addr == err_addr)});
    end
    if (!rst && redir_v) begin
      epoch++;
      exp_q.delete();
      exp_pc = redir_pc_v & ~64'd3;
    end
    if (rst) begin
      pend.delete();
      exp_q.delete();
      epoch++;
      exp_pc = 64'h0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    int k;
    k = 0;
    gnt_v = 1'b0; ready_v = 1'b1; redir_v = 1'b0;
    while ((pend.size() != 0 || exp_q.size() != 0 || instr_valid_o) && k < 60) begin
      step();
      k++;
    end
    check("drain_done", 64'(pend.size() + exp_q.size()) + 64'(instr_valid_o), 64'd0);
  endtask

  initial begin
    int g0, p0, k;
    rst = 1'b1; redir_v = 1'b0; redir_pc_v = 64'h0; ready_v = 1'b1; gnt_v = 1'b1;
    watch_flush = 1'b0; err_addr = 64'h8; exp_pc = 64'h0;
    @(posedge clk); #1;

    // Reset and the first cycle after it keep the ports quiet.
    repeat (3) begin
      step();
      check("rst_req", 64'(req_q), 64'd0);
      check("rst_valid", 64'(valid_q), 64'd0);
    end
    rst = 1'b0;
    step();
    check("post_rst_req", 64'(req_q), 64'd0);
    check("post_rst_valid", 64'(valid_q), 64'd0);

    // Streaming with zero-wait memory; word at 0x8 carries a bus error.
    repeat (6) step();
    p0 = n_pops;
    repeat (10) step();
    check("throughput", 64'(n_pops - p0), 64'd10);
    check("err_seen", 64'(n_err_seen), 64'd1);

    // Backpressure: exactly DEPTH grants, then one more per popped slot.
    drain();
    gnt_v = 1'b1; ready_v = 1'b0;
    g0 = n_grants;
    repeat (10) step();
    check("bp_grants", 64'(n_grants - g0), 64'd4);
    check("bp_req_low", 64'(req_q), 64'd0);
    ready_v = 1'b1;
    step();
    ready_v = 1'b0;
    repeat (5) step();
    check("bp_one_more", 64'(n_grants - g0), 64'd5);
    check("bp_req_low2", 64'(req_q), 64'd0);

    // Redirect with two requests in flight; both responses must be dropped.
    drain();
    lat = 3; gnt_v = 1'b1;
    g0 = n_grants;
    step(); step();
    gnt_v = 1'b0;
    check("t3_grants", 64'(n_grants - g0), 64'd2);
    watch_flush = 1'b1;
    redir_v = 1'b1; redir_pc_v = 64'h1002;
    step();
    redir_v = 1'b0; gnt_v = 1'b1;
    k = 0;
    while (pend.size() > 0 && k < 20) begin step(); k++; end
    watch_flush = 1'b0;
    step();
    check("t3_req_after", 64'(req_q), 64'd1);
    check("t3_addr_after", addr_q, 64'h1000);
    p0 = n_pops;
    repeat (6) step();
    check("t3_delivered", 64'(n_pops - p0 > 0), 64'd1);

    // Redirect in a cycle with a response arriving and gnt high.
    drain();
    lat = 2; gnt_v = 1'b1; ready_v = 1'b1;
    k = 0;
    while (!(pend.size() >= 2 && pend[0].due <= cyc) && k < 20) begin step(); k++; end
    check("t4_setup", 64'(pend.size()), 64'd2);
    redir_v = 1'b1; redir_pc_v = 64'h2000;
    step();
    redir_v = 1'b0;
    repeat (10) step();

    // Grant stall holds req/addr; a redirect during it moves addr without discards.
    drain();
    lat = 1;
    g0 = n_grants;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_req", 64'(req_q), 64'd1);
      check("stall_addr", addr_q, exp_pc);
    end
    redir_v = 1'b1; redir_pc_v = 64'h3004;
    step();
    redir_v = 1'b0; gnt_v = 1'b1;
    step();
    check("redir_req_n1", 64'(req_q), 64'd1);
    check("redir_addr_n1", addr_q, 64'h3004);
    step();
    check("redir_valid_n2", 64'(valid_q), 64'd0);
    step();
    check("redir_valid_n3", 64'(valid_q), 64'd1);
    repeat (4) step();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
